// File: rtl/scan_pattern_driver.sv
// Scan-test sequencer for a CHAIN_LEN-bit up-counter stage.
// Each accepted start shifts a pattern into the counter's scan chain, pulses the
// counter's increment for the requested number of cycles, then unloads the chain
// and compares the unloaded value against pattern + run cycles (mod 2^CHAIN_LEN).
// All outputs are registered. The next-state logic also produces the next output
// values, so each output changes on the same edge as the state that drives it.
module scan_pattern_driver #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned RUN_W     = 8
) (
  input  logic                 BrdClk,
  input  logic                 aReset_n,
  input  logic                 bStart,
  input  logic [CHAIN_LEN-1:0] bPattern,
  input  logic [RUN_W-1:0]     bRunCycles,
  input  logic                 bScanRet,
  output logic                 aScanEn,
  output logic                 bScanIn,
  output logic                 aIncrement,
  output logic                 bBusy,
  output logic                 bDone,
  output logic [CHAIN_LEN-1:0] bCapture,
  output logic                 bPass
);

  localparam int unsigned BitW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CntW = (RUN_W > BitW) ? RUN_W : BitW;

  typedef enum logic [2:0] {
    StIdle,
    StShiftIn,
    StRun,
    StShiftOut,
    StDone
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic [CntW-1:0]      r_cnt;
  logic [CntW-1:0]      w_cnt_d;
  logic [CHAIN_LEN-1:0] r_pattern;
  logic [RUN_W-1:0]     r_run;
  logic [CHAIN_LEN-1:0] r_expected;
  logic [CHAIN_LEN-1:0] r_shreg;

  logic                 r_scan_en;
  logic                 r_scan_in;
  logic                 r_inc;
  logic                 r_busy;
  logic                 r_done;
  logic [CHAIN_LEN-1:0] r_capture;
  logic                 r_pass;

  logic                 w_accept;
  logic [CHAIN_LEN-1:0] w_pattern;
  logic [CHAIN_LEN-1:0] w_pat_sh;
  logic [CHAIN_LEN-1:0] w_expected;
  logic [CntW-1:0]      w_chain_last;
  logic [CntW-1:0]      w_run_last;
  logic                 w_scan_en_d;
  logic                 w_scan_in_d;
  logic                 w_inc_d;
  logic                 w_busy_d;

  assign w_accept     = (r_state == StIdle) && bStart;
  // On the accepting edge the pattern register is not yet loaded, so drive from the port.
  assign w_pattern    = w_accept ? bPattern : r_pattern;
  assign w_expected   = bPattern + CHAIN_LEN'(bRunCycles);
  assign w_chain_last = CntW'(CHAIN_LEN - 1);
  assign w_run_last   = CntW'(r_run) - CntW'(1);
  // Bit to present in shift-in cycle k is pattern[CHAIN_LEN-1-k]: shift left, take MSB.
  assign w_pat_sh     = w_pattern << w_cnt_d;

  // Next-state and next-output decode.
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_scan_en_d = 1'b0;
    w_scan_in_d = 1'b0;
    w_inc_d     = 1'b0;
    w_busy_d    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bStart) begin
          w_state_d = StShiftIn;
          w_cnt_d   = '0;
        end
      end
      StShiftIn: begin
        if (r_cnt == w_chain_last) begin
          w_cnt_d   = '0;
          // A zero run count goes straight to unload.
          w_state_d = (r_run == '0) ? StShiftOut : StRun;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StRun: begin
        if (r_cnt == w_run_last) begin
          w_cnt_d   = '0;
          w_state_d = StShiftOut;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StShiftOut: begin
        if (r_cnt == w_chain_last) begin
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase

    w_busy_d    = (w_state_d != StIdle);
    w_scan_en_d = (w_state_d == StShiftIn) || (w_state_d == StShiftOut);
    w_inc_d     = (w_state_d == StRun);
    // Unload shifts zeros in so the chain is left flushed.
    w_scan_in_d = (w_state_d == StShiftIn) ? w_pat_sh[CHAIN_LEN-1] : 1'b0;
  end

  // State, counter and registered counter-control outputs.
  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_scan_en <= 1'b0;
      r_scan_in <= 1'b0;
      r_inc     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_scan_en <= w_scan_en_d;
      r_scan_in <= w_scan_in_d;
      r_inc     <= w_inc_d;
      r_busy    <= w_busy_d;
    end
  end

  // Latch the test parameters and the expected result on an accepted start.
  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_pattern  <= '0;
      r_run      <= '0;
      r_expected <= '0;
    end else if (w_accept) begin
      r_pattern  <= bPattern;
      r_run      <= bRunCycles;
      r_expected <= w_expected;
    end
  end

  // Capture shift register: samples the pre-shift MSB on each unload edge.
  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_shreg <= '0;
    end else if (r_state == StShiftOut) begin
      r_shreg <= {r_shreg[CHAIN_LEN-2:0], bScanRet};
    end
  end

  // Result outputs: publish on leaving DONE, hold until the next accepted start.
  always_ff @(posedge BrdClk or negedge aReset_n) begin
    if (!aReset_n) begin
      r_done    <= 1'b0;
      r_capture <= '0;
      r_pass    <= 1'b0;
    end else begin
      r_done <= (r_state == StDone);
      if (w_accept) begin
        r_capture <= '0;
        r_pass    <= 1'b0;
      end else if (r_state == StDone) begin
        r_capture <= r_shreg;
        r_pass    <= (r_shreg == r_expected);
      end
    end
  end

  assign aScanEn    = r_scan_en;
  assign bScanIn    = r_scan_in;
  assign aIncrement = r_inc;
  assign bBusy      = r_busy;
  assign bDone      = r_done;
  assign bCapture   = r_capture;
  assign bPass      = r_pass;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Bench for scan_pattern_driver: drives a behavioural 4-bit counter stage from the
// DUT's scan/increment outputs and checks each sequence against table expectations
// queued at start and popped when bDone is seen.
module tb_scan_pattern_driver;

  logic       clk;
  logic       rst_n;
  logic       bStart;
  logic [3:0] bPattern;
  logic [7:0] bRunCycles;
  logic       bScanRet;
  logic       aScanEn;
  logic       bScanIn;
  logic       aIncrement;
  logic       bBusy;
  logic       bDone;
  logic [3:0] bCapture;
  logic       bPass;

  logic [3:0] ctr;
  logic       force0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] pattern;
    logic [7:0] run;
    bit         force0;
    int         inject_k;
    logic [3:0] exp_cap;
    bit         exp_pass;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  vec_t v;

  scan_pattern_driver #(
    .CHAIN_LEN(4),
    .RUN_W    (8)
  ) u_dut (
    .BrdClk    (clk),
    .aReset_n  (rst_n),
    .bStart    (bStart),
    .bPattern  (bPattern),
    .bRunCycles(bRunCycles),
    .bScanRet  (bScanRet),
    .aScanEn   (aScanEn),
    .bScanIn   (bScanIn),
    .aIncrement(aIncrement),
    .bBusy     (bBusy),
    .bDone     (bDone),
    .bCapture  (bCapture),
    .bPass     (bPass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter stage model, reset by the same net as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctr <= 4'd0;
    else if (aScanEn) ctr <= {ctr[2:0], bScanIn};
    else if (aIncrement) ctr <= ctr + 4'd1;
  end

  assign bScanRet = force0 ? 1'b0 : ctr[3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a start request; returns #1 after the start edge.
  task automatic start_seq(input logic [3:0] pat, input logic [7:0] run, input bit f0,
                           input bit hold);
    @(negedge clk);
    bPattern   = pat;
    bRunCycles = run;
    force0     = f0;
    bStart     = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bStart = 1'b0;
  endtask

  // Called #1 after the start edge; follows the sequence until bDone, checks against scoreboard.
  task automatic finish_seq(input int run, input int inject_k, input bit check_hold);
    int k = 0;
    int en = 0;
    int inc = 0;
    int both = 0;
    int busy_drop = 0;
    logic [3:0] si = 4'd0;
    bit done = 0;
    vec_t e;
    check("clear_capture", int'(bCapture), 0);
    check("clear_pass", int'(bPass), 0);
    while (!done && k < 400) begin
      if (bDone) begin
        done = 1;
      end else begin
        if (aScanEn) begin
          if (en < 4) si = {si[2:0], bScanIn};
          en++;
        end
        if (aIncrement) inc++;
        if (aScanEn && aIncrement) both++;
        if (!bBusy) busy_drop++;
        if (k == inject_k) begin
          bStart     = 1'b1;
          bPattern   = 4'b0001;
          bRunCycles = 8'd0;
        end else if (inject_k >= 0 && k == inject_k + 1) begin
          bStart = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("done_seen", int'(done), 1);
    check("latency", k, 9 + run);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("capture", int'(bCapture), int'(e.exp_cap));
      check("pass", int'(bPass), int'(e.exp_pass));
      check("scan_in_bits", int'(si), int'(e.pattern));
    end
    check("scan_en_cycles", en, 8);
    check("inc_cycles", inc, run);
    check("en_inc_overlap", both, 0);
    check("busy_drop", busy_drop, 0);
    check("counter_flushed", int'(ctr), 0);
    if (check_hold) begin
      @(posedge clk);
      #1;
      check("done_one_cycle", int'(bDone), 0);
      check("idle_not_busy", int'(bBusy), 0);
      check("capture_held", int'(bCapture), int'(e.exp_cap));
      check("pass_held", int'(bPass), int'(e.exp_pass));
    end
    force0 = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_scan_en"}, int'(aScanEn), 0);
    check({tag, "_scan_in"}, int'(bScanIn), 0);
    check({tag, "_inc"}, int'(aIncrement), 0);
    check({tag, "_busy"}, int'(bBusy), 0);
    check({tag, "_done"}, int'(bDone), 0);
    check({tag, "_capture"}, int'(bCapture), 0);
    check({tag, "_pass"}, int'(bPass), 0);
  endtask

  initial begin
    // pattern, run, force0, inject_k, expected capture, expected pass
    vecs[0] = '{4'b0110, 8'd1,  1'b0, -1, 4'b0111, 1'b1};
    vecs[1] = '{4'b1111, 8'd1,  1'b0, -1, 4'b0000, 1'b1};
    vecs[2] = '{4'b0000, 8'd20, 1'b0, -1, 4'b0100, 1'b1};
    vecs[3] = '{4'b1010, 8'd0,  1'b0, -1, 4'b1010, 1'b1};
    vecs[4] = '{4'b0100, 8'd3,  1'b0,  5, 4'b0111, 1'b1};
    vecs[5] = '{4'b0011, 8'd2,  1'b1, -1, 4'b0000, 1'b0};
    vecs[6] = '{4'b1001, 8'd15, 1'b0, -1, 4'b1000, 1'b1};

    rst_n      = 1'b0;
    bStart     = 1'b0;
    bPattern   = 4'd0;
    bRunCycles = 8'd0;
    force0     = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      start_seq(v.pattern, v.run, v.force0, 1'b0);
      sb.push_back(v);
      finish_seq(int'(v.run), v.inject_k, 1'b1);
    end

    // Start held high through DONE: second sequence begins on the first IDLE cycle.
    v = '{4'b0010, 8'd0, 1'b0, -1, 4'b0010, 1'b1};
    start_seq(v.pattern, v.run, 1'b0, 1'b1);
    sb.push_back(v);
    finish_seq(0, -1, 1'b0);
    @(posedge clk);
    #1;
    check("restart_busy", int'(bBusy), 1);
    check("restart_done_low", int'(bDone), 0);
    bStart = 1'b0;
    sb.push_back(v);
    finish_seq(0, -1, 1'b1);

    // Reset during SHIFT_IN cycle 2.
    start_seq(4'b1100, 8'd5, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_scan_en", int'(aScanEn), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    check("mid_reset_counter", int'(ctr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{4'b0101, 8'd3, 1'b0, -1, 4'b1000, 1'b1};
    start_seq(v.pattern, v.run, 1'b0, 1'b0);
    sb.push_back(v);
    finish_seq(3, -1, 1'b1);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
